// File: rtl/filter_sample_scheduler_pkg.sv
// Shared definitions for the filter sample scheduler: default widths,
// scheduler state encoding, byte-phase constants and a small state helper.
package filter_sample_scheduler_pkg;

  localparam int DATA_W_DEFAULT   = 8;
  localparam int SAMPLE_W_DEFAULT = 16;
  localparam int TIMEOUT_DEFAULT  = 16;

  // Scheduler states; encoding 3'd7 is unused and recovers to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_FILT = 3'd2,
    ST_TX_HI     = 3'd3,
    ST_WAIT_HI   = 3'd4,
    ST_TX_LO     = 3'd5,
    ST_WAIT_LO   = 3'd6
  } sched_state_e;

  // Which byte of the pair the next rx_done_tick belongs to.
  localparam logic PHASE_HIGH = 1'b0;
  localparam logic PHASE_LOW  = 1'b1;

  // True for the states that issue a byte to the UART transmitter.
  function automatic logic is_tx_state(input sched_state_e st);
    return (st == ST_TX_HI) || (st == ST_TX_LO);
  endfunction

endpackage

// File: rtl/filter_sample_scheduler_sample_assembler.sv
// Packs received UART bytes (high byte first) into samples and holds at most
// one complete sample until the scheduler consumes it. A sample completing
// while the buffer is occupied and not being consumed is dropped.
module sample_assembler
  import filter_sample_scheduler_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_done_tick,
  input  logic [DATA_W-1:0]   rx_dout,
  input  logic                consume,
  output logic                buf_valid,
  output logic [SAMPLE_W-1:0] buf_data,
  output logic                overrun
);

  logic                phase_r;
  logic [DATA_W-1:0]   hi_byte_r;
  logic                buf_valid_r;
  logic [SAMPLE_W-1:0] buf_data_r;
  logic                overrun_r;

  logic complete_s;
  logic slot_free_s;
  logic load_s;
  logic drop_s;

  // Decide whether this byte closes a pair and whether the buffer can accept it
  always_comb begin
    complete_s  = 1'b0;
    slot_free_s = 1'b0;
    load_s      = 1'b0;
    drop_s      = 1'b0;
    if (rx_done_tick && (phase_r == PHASE_LOW)) begin
      complete_s = 1'b1;
    end else begin
      complete_s = 1'b0;
    end
    // A consume in this cycle frees the slot, so a simultaneous load is legal.
    slot_free_s = (!buf_valid_r) || consume;
    load_s      = complete_s && slot_free_s;
    drop_s      = complete_s && (!slot_free_s);
  end

  // Byte-phase tracker and high-byte holding register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r   <= PHASE_HIGH;
      hi_byte_r <= {DATA_W{1'b0}};
    end else if (rx_done_tick) begin
      if (phase_r == PHASE_HIGH) begin
        hi_byte_r <= rx_dout;
        phase_r   <= PHASE_LOW;
      end else begin
        phase_r   <= PHASE_HIGH;
      end
    end
  end

  // One-deep sample buffer: load wins over consume so the slot stays full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid_r <= 1'b0;
      buf_data_r  <= {SAMPLE_W{1'b0}};
    end else if (load_s) begin
      buf_valid_r <= 1'b1;
      buf_data_r  <= {hi_byte_r, rx_dout};
    end else if (consume) begin
      buf_valid_r <= 1'b0;
    end
  end

  // One-cycle strobe reporting a dropped sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= drop_s;
    end
  end

  assign buf_valid = buf_valid_r;
  assign buf_data  = buf_data_r;
  assign overrun   = overrun_r;

endmodule

// File: rtl/filter_sample_scheduler.sv
// Frame-level controller between UART receiver, filter sequencer and UART
// transmitter. Each buffered sample is started into the filter, the result is
// awaited with a timeout, and the 16-bit result is sent as two bytes.
module filter_sample_scheduler
  import filter_sample_scheduler_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_done_tick,
  input  logic [DATA_W-1:0]   rx_dout,
  input  logic                filt_listo,
  input  logic [SAMPLE_W-1:0] filt_result,
  input  logic                tx_done_tick,
  input  logic                clear_err,
  output logic                filt_start,
  output logic [SAMPLE_W-1:0] filt_sample,
  output logic                tx_start,
  output logic [DATA_W-1:0]   tx_din,
  output logic                busy,
  output logic                overrun,
  output logic                err_overrun,
  output logic                err_timeout
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  sched_state_e        state_r;
  sched_state_e        state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   res_lo_r;
  logic                filt_start_r;
  logic [SAMPLE_W-1:0] filt_sample_r;
  logic                tx_start_r;
  logic [DATA_W-1:0]   tx_din_r;
  logic                err_overrun_r;
  logic                err_timeout_r;

  logic                buf_valid_s;
  logic [SAMPLE_W-1:0] buf_data_s;
  logic                overrun_s;
  logic                consume_s;
  logic                listo_take_s;
  logic                timeout_hit_s;

  // The buffer is released in the START cycle, after its data was captured.
  assign consume_s = (state_r == ST_START);

  sample_assembler #(
    .DATA_W   (DATA_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_assembler (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .consume      (consume_s),
    .buf_valid    (buf_valid_s),
    .buf_data     (buf_data_s),
    .overrun      (overrun_s)
  );

  // Next-state decode plus the two qualified filter events
  always_comb begin
    state_nxt_s   = state_r;
    listo_take_s  = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (buf_valid_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_nxt_s = ST_WAIT_FILT;
      end
      ST_WAIT_FILT: begin
        // listo on the terminal count still counts as a completion
        if (filt_listo) begin
          listo_take_s = 1'b1;
          state_nxt_s  = ST_TX_HI;
        end else if (cnt_r == CNT_LAST) begin
          timeout_hit_s = 1'b1;
          state_nxt_s   = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_FILT;
        end
      end
      ST_TX_HI: begin
        state_nxt_s = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (tx_done_tick) begin
          state_nxt_s = ST_TX_LO;
        end else begin
          state_nxt_s = ST_WAIT_HI;
        end
      end
      ST_TX_LO: begin
        state_nxt_s = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (tx_done_tick) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_LO;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Scheduler state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Filter timeout counter: cleared in START, advances each idle WAIT_FILT cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_START) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_WAIT_FILT) && !listo_take_s && !timeout_hit_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Filter-side outputs, registered so they line up with the START state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_start_r  <= 1'b0;
      filt_sample_r <= {SAMPLE_W{1'b0}};
    end else begin
      filt_start_r <= (state_nxt_s == ST_START);
      if ((state_r == ST_IDLE) && (state_nxt_s == ST_START)) begin
        filt_sample_r <= buf_data_s;
      end
    end
  end

  // Result capture and transmit byte/strobe; the high byte goes straight to tx_din
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_lo_r   <= {DATA_W{1'b0}};
      tx_start_r <= 1'b0;
      tx_din_r   <= {DATA_W{1'b0}};
    end else begin
      tx_start_r <= is_tx_state(state_nxt_s);
      if (listo_take_s) begin
        res_lo_r <= filt_result[DATA_W-1:0];
        tx_din_r <= filt_result[SAMPLE_W-1:DATA_W];
      end else if ((state_r == ST_WAIT_HI) && (state_nxt_s == ST_TX_LO)) begin
        tx_din_r <= res_lo_r;
      end
    end
  end

  // Sticky error flags: a new error in the same cycle beats clear_err
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_overrun_r <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      if (overrun_s) begin
        err_overrun_r <= 1'b1;
      end else if (clear_err) begin
        err_overrun_r <= 1'b0;
      end
      if (timeout_hit_s) begin
        err_timeout_r <= 1'b1;
      end else if (clear_err) begin
        err_timeout_r <= 1'b0;
      end
    end
  end

  assign filt_start  = filt_start_r;
  assign filt_sample = filt_sample_r;
  assign tx_start    = tx_start_r;
  assign tx_din      = tx_din_r;
  assign busy        = (state_r != ST_IDLE) || buf_valid_s;
  assign overrun     = overrun_s;
  assign err_overrun = err_overrun_r;
  assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_filter_sample_scheduler.sv
// Scoreboard bench for filter_sample_scheduler: stimulus pushes expected
// samples, the filter responder pushes expected tx bytes, and a monitor pops
// and compares whenever the DUT strobes filt_start or tx_start.
`timescale 1ns/1ps
module tb_filter_sample_scheduler;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_done_tick = 1'b0;
  logic [7:0]  rx_dout = 8'h00;
  logic        filt_listo = 1'b0;
  logic [15:0] filt_result = 16'h0000;
  logic        tx_done_tick = 1'b0;
  logic        clear_err = 1'b0;
  logic        filt_start;
  logic [15:0] filt_sample;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic        busy;
  logic        overrun;
  logic        err_overrun;
  logic        err_timeout;

  filter_sample_scheduler dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_dout(rx_dout),
    .filt_listo(filt_listo), .filt_result(filt_result), .tx_done_tick(tx_done_tick),
    .clear_err(clear_err), .filt_start(filt_start), .filt_sample(filt_sample),
    .tx_start(tx_start), .tx_din(tx_din), .busy(busy), .overrun(overrun),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] exp_samples[$];
  logic [7:0]  exp_tx[$];
  int start_count = 0, last_start_cyc = 0, tx_count = 0, ovr_seen = 0;
  int filt_delay = 3;       // 0 = never answer; > TO = answer after the abort
  logic [15:0] filt_res_v = 16'h0000;
  int tx_delay = 2;
  int epoch = 0;
  bit filt_pend = 1'b0, tx_pend = 1'b0;
  logic [7:0] cur_tx = 8'h00;
  bit prev_fs = 1'b0, prev_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic tick_byte(input logic [7:0] b);
    rx_dout = b; rx_done_tick = 1'b1;
    step(1);
    rx_done_tick = 1'b0;
  endtask

  // Sends a byte pair; returns the cycle index of the second tick.
  task automatic send_pair(input logic [7:0] hi, input logic [7:0] lo, input bit expect_start,
                           output int lo_cyc);
    tick_byte(hi);
    step($urandom_range(0, 2));
    lo_cyc = cyc;
    if (expect_start) exp_samples.push_back({hi, lo});
    tick_byte(lo);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || filt_pend || tx_pend) && n < 400) begin step(1); n++; end
    chk(name, (n < 400), 1'b1);
  endtask

  task automatic wait_starts(input int target, input string name);
    int n = 0;
    while (start_count < target && n < 300) begin step(1); n++; end
    chk(name, (start_count >= target), 1'b1);
  endtask

  task automatic wait_txs(input int target, input string name);
    int n = 0;
    while (tx_count < target && n < 300) begin step(1); n++; end
    chk(name, (tx_count >= target), 1'b1);
  endtask

  // Cycle counter: value after posedge k is k
  initial forever begin @(posedge clk); cyc++; end

  // Monitor: pops expectations whenever the DUT presents a strobe
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (filt_start) begin
        start_count++;
        last_start_cyc = cyc;
        chk("filt_start_single", prev_fs, 1'b0);
        if (exp_samples.size() == 0) chk("spurious_filt_start", filt_start, 1'b0);
        else chk("filt_sample", filt_sample, exp_samples.pop_front());
      end
      if (tx_start) begin
        tx_count++;
        if (exp_tx.size() == 0) chk("spurious_tx_start", tx_start, 1'b0);
        else begin cur_tx = exp_tx.pop_front(); chk("tx_din", tx_din, cur_tx); end
      end
      if (tx_done_tick && tx_pend) chk("tx_din_stable", tx_din, cur_tx);
      if (overrun) begin
        ovr_seen++;
        chk("overrun_single", prev_ovr, 1'b0);
      end
    end
    prev_fs = filt_start;
    prev_ovr = overrun;
  end

  // Filter sequencer model: answers filt_start after filt_delay cycles
  initial begin
    int d, ep;
    logic [15:0] r;
    forever begin
      @(negedge clk);
      if (reset && filt_start) begin
        d = filt_delay; ep = epoch; r = filt_res_v;
        if (d > 0) begin
          filt_pend = 1'b1;
          repeat (d) @(posedge clk);
          #1;
          if (ep == epoch) begin
            // Only a reply inside the timeout window produces a transmission.
            if (d <= TO) begin exp_tx.push_back(r[15:8]); exp_tx.push_back(r[7:0]); end
            filt_result = r; filt_listo = 1'b1;
            @(posedge clk); #1;
            filt_listo = 1'b0; filt_result = 16'hDEAD;
          end
          filt_pend = 1'b0;
        end
      end
    end
  end

  // UART transmitter model: reports byte done tx_delay cycles after tx_start
  initial begin
    int td, ep;
    forever begin
      @(negedge clk);
      if (reset && tx_start) begin
        td = tx_delay; ep = epoch; tx_pend = 1'b1;
        repeat (td) @(posedge clk);
        #1;
        if (ep == epoch) begin
          tx_done_tick = 1'b1;
          @(posedge clk); #1;
          tx_done_tick = 1'b0;
        end
        tx_pend = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t2, sc, txc, ovr0, s;
    bit exp_to;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes_flags", {filt_start, tx_start, busy, overrun, err_overrun, err_timeout}, 6'b0);
    chk("reset_filt_sample", filt_sample, 16'h0000);
    chk("reset_tx_din", tx_din, 8'h00);
    reset = 1'b1;
    step(2);

    // Nominal transaction with start latency
    filt_delay = 4; filt_res_v = 16'hABCD; tx_delay = 3;
    txc = tx_count;
    send_pair(8'h12, 8'h34, 1'b1, t2);
    wait_idle("nominal_idle");
    chk("nominal_start_latency", last_start_cyc - t2, 2);
    chk("nominal_tx_count", tx_count - txc, 2);
    chk("nominal_busy_low", busy, 1'b0);
    chk("nominal_no_err", {err_overrun, err_timeout}, 2'b00);

    // listo exactly on the terminal count wins over the timeout
    filt_delay = TO; filt_res_v = 16'h1E2F; txc = tx_count;
    send_pair(8'h9A, 8'hBC, 1'b1, t2);
    wait_idle("terminal_listo_idle");
    chk("terminal_listo_no_timeout", err_timeout, 1'b0);
    chk("terminal_listo_tx_count", tx_count - txc, 2);

    // Timeout colliding with clear_err, then clear_err alone
    filt_delay = 0; sc = start_count; txc = tx_count;
    send_pair(8'hC3, 8'h5A, 1'b1, t2);
    wait_starts(sc + 1, "timeout_start_seen");
    s = last_start_cyc;
    while (cyc < s + TO) step(1);
    chk("timeout_not_early", err_timeout, 1'b0);
    clear_err = 1'b1;
    step(1);
    chk("timeout_beats_clear", err_timeout, 1'b1);
    chk("timeout_back_to_idle", busy, 1'b0);
    step(1);
    clear_err = 1'b0;
    chk("clear_err_clears_timeout", err_timeout, 1'b0);
    chk("timeout_no_tx", tx_count - txc, 0);

    // Late listo after the abort is ignored; stray tx_done in IDLE too
    filt_delay = 20; txc = tx_count;
    send_pair(8'h0F, 8'hF0, 1'b1, t2);
    wait_idle("late_listo_idle");
    chk("late_listo_timeout", err_timeout, 1'b1);
    chk("late_listo_no_tx", tx_count - txc, 0);
    tx_done_tick = 1'b1; step(1); tx_done_tick = 1'b0; step(2);
    chk("stray_tx_done_ignored", {busy, tx_count - txc}, 33'h0);
    clear_err = 1'b1; step(1); clear_err = 0;

    // Second pair completes in the START cycle of the first: no overrun
    filt_delay = 3; filt_res_v = 16'h7788; tx_delay = 2;
    sc = start_count; ovr0 = ovr_seen;
    exp_samples.push_back(16'h1122);
    exp_samples.push_back(16'h3344);
    tick_byte(8'h11); tick_byte(8'h22); tick_byte(8'h33); tick_byte(8'h44);
    wait_idle("simul_idle");
    chk("simul_no_overrun", ovr_seen - ovr0, 0);
    chk("simul_err_overrun", err_overrun, 1'b0);
    chk("simul_two_starts", start_count - sc, 2);

    // Overrun while waiting on the high byte transmission
    filt_delay = 2; filt_res_v = 16'h4D5E; tx_delay = 40;
    sc = start_count; ovr0 = ovr_seen; txc = tx_count;
    send_pair(8'hA1, 8'hB2, 1'b1, t2);
    wait_txs(txc + 1, "overrun_hi_seen");
    filt_res_v = 16'h6F70;
    send_pair(8'h01, 8'h02, 1'b1, t2);
    send_pair(8'h03, 8'h04, 1'b0, t2);
    tx_delay = 2;
    wait_idle("overrun_idle");
    chk("overrun_pulse_count", ovr_seen - ovr0, 1);
    chk("overrun_sticky", err_overrun, 1'b1);
    chk("overrun_two_starts", start_count - sc, 2);
    clear_err = 1'b1; step(1); clear_err = 1'b0;
    chk("clear_err_clears_overrun", err_overrun, 1'b0);

    // Reset in WAIT_LO with a partial byte pending
    filt_delay = 2; filt_res_v = 16'h2468; tx_delay = 2; txc = tx_count;
    send_pair(8'hCA, 8'hFE, 1'b1, t2);
    wait_txs(txc + 1, "reset_hi_seen");
    tx_delay = 30;
    wait_txs(txc + 2, "reset_lo_seen");
    tick_byte(8'h77);
    step(1);
    #2;
    reset = 1'b0;
    epoch++;
    #1;
    chk("async_reset_strobes_flags", {filt_start, tx_start, busy, overrun, err_overrun, err_timeout}, 6'b0);
    chk("async_reset_data", {filt_sample, tx_din}, 24'h0);
    exp_tx.delete();
    step(3);
    reset = 1'b1;
    sc = start_count; txc = tx_count;
    wait_idle("post_reset_quiesce");
    tick_byte(8'h55);
    step(10);
    chk("single_byte_no_start", start_count - sc, 0);
    filt_delay = 3; filt_res_v = 16'h1357; tx_delay = 2;
    exp_samples.push_back(16'h5566);
    tick_byte(8'h66);
    wait_idle("post_reset_idle");
    chk("post_reset_start", start_count - sc, 1);
    chk("post_reset_tx_count", tx_count - txc, 2);

    // Randomized transactions against the transaction-level model
    for (int i = 0; i < 25; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) filt_delay = 0;
      else if (sel == 1) filt_delay = 20;
      else filt_delay = $urandom_range(1, TO);
      filt_res_v = 16'($urandom);
      tx_delay = $urandom_range(1, 6);
      sc = start_count; txc = tx_count; ovr0 = ovr_seen;
      send_pair(8'($urandom), 8'($urandom), 1'b1, t2);
      wait_idle("rand_idle");
      exp_to = (filt_delay == 0) || (filt_delay > TO);
      chk("rand_start_latency", last_start_cyc - t2, 2);
      chk("rand_err_timeout", err_timeout, exp_to);
      chk("rand_tx_count", tx_count - txc, exp_to ? 2'd0 : 2'd2);
      chk("rand_no_overrun", ovr_seen - ovr0, 0);
      if (exp_to) begin clear_err = 1'b1; step(1); clear_err = 1'b0; end
    end

    step(5);
    chk("leftover_samples", exp_samples.size(), 0);
    chk("leftover_tx", exp_tx.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
